// File: rtl/h_dmux8_arbiter.sv
// Round-robin arbiter for eight requesters sharing one 8-way demultiplexed resource.
// Drives the DMux select (gnt_sel) and enable (gnt_valid) plus the decoded one-hot grant.
module h_dmux8_arbiter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic       gnt_valid,
  output logic [2:0] gnt_sel,
  output logic [7:0] gnt
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  state_t           state, state_nx;
  logic [2:0]       ptr, ptr_nx;
  logic [2:0]       sel_nx;
  logic             valid_nx;
  logic [7:0]       gnt_nx;
  logic [CNT_W-1:0] hold_cnt, hold_nx;

  logic [7:0]       others;
  logic [7:0]       mask;
  logic [2:0]       base;
  logic [2:0]       idx;
  logic [2:0]       win;
  logic             found;
  logic             release_g;
  logic             timeout;

  // Search base and candidate set depend only on registered state, so the
  // priority search below never feeds back into itself.
  assign others    = req & ~(8'b1 << gnt_sel);
  assign mask      = (state == GRANT) ? others : req;
  assign base      = ((state == GRANT) ? gnt_sel : ptr) + 3'd1;
  assign release_g = (state == GRANT) && !req[gnt_sel];
  assign timeout   = (MAX_HOLD != 0) && (state == GRANT) && req[gnt_sel] &&
                     (hold_cnt == HOLD_LAST) && (others != '0);

  always_comb begin
    found = 1'b0;
    win   = base;
    idx   = base;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = base + 3'(i);
      if (!found && mask[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    sel_nx   = gnt_sel;
    valid_nx = gnt_valid;
    hold_nx  = hold_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_nx = GRANT;
          valid_nx = 1'b1;
          sel_nx   = win;
          hold_nx  = '0;
        end
      end
      GRANT: begin
        if (release_g || timeout) begin
          ptr_nx  = gnt_sel;
          hold_nx = '0;
          if (found) begin
            sel_nx = win;
          end else begin
            state_nx = IDLE;
            valid_nx = 1'b0;
          end
        end else if ((MAX_HOLD != 0) && (hold_cnt != HOLD_LAST)) begin
          hold_nx = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        valid_nx = 1'b0;
      end
    endcase
    gnt_nx = valid_nx ? (8'b1 << sel_nx) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 3'd7;
      hold_cnt  <= '0;
      gnt_valid <= 1'b0;
      gnt_sel   <= '0;
      gnt       <= '0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      hold_cnt  <= hold_nx;
      gnt_valid <= valid_nx;
      gnt_sel   <= sel_nx;
      gnt       <= gnt_nx;
    end
  end

endmodule
